// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory: one access per cycle, registered read return.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution instead of fixed A priority with starvation guard.
module data_mem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          a_req_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_wdata_i,
  output logic          a_gnt_o,
  output logic          a_rvalid_o,
  output logic [DW-1:0] a_rdata_o,
  input  logic          b_req_i,
  input  logic          b_we_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] b_wdata_i,
  output logic          b_gnt_o,
  output logic          b_rvalid_o,
  output logic [DW-1:0] b_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_wren_o,
  input  logic [DW-1:0] mem_rdata_i
);

  logic          b_wins;
  logic [AW-1:0] last_addr;

`ifdef DMEM_ARB_RR_EN
  // Set after an A grant: B is owed the next conflict.
  logic last_b;
`else
  logic [7:0] wait_cnt;
`endif

  always_comb begin
    b_wins = 1'b0;
    if (b_req_i && !a_req_i) begin
      b_wins = 1'b1;
    end else if (a_req_i && b_req_i) begin
`ifdef DMEM_ARB_RR_EN
      b_wins = last_b;
`else
      b_wins = (wait_cnt == 8'(MAX_WAIT));
`endif
    end
  end

  // Grants are masked while reset is high so nothing reaches the memory.
  assign a_gnt_o = !rst_i && a_req_i && !b_wins;
  assign b_gnt_o = !rst_i && b_req_i && b_wins;

  always_comb begin
    mem_addr_o  = last_addr;
    mem_wdata_o = '0;
    mem_wren_o  = 1'b0;
    if (a_gnt_o) begin
      mem_addr_o  = a_addr_i;
      mem_wdata_o = a_wdata_i;
      mem_wren_o  = a_we_i;
    end else if (b_gnt_o) begin
      mem_addr_o  = b_addr_i;
      mem_wdata_o = b_wdata_i;
      mem_wren_o  = b_we_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_addr  <= '0;
      a_rvalid_o <= 1'b0;
      a_rdata_o  <= '0;
      b_rvalid_o <= 1'b0;
      b_rdata_o  <= '0;
    end else begin
      if (a_gnt_o)      last_addr <= a_addr_i;
      else if (b_gnt_o) last_addr <= b_addr_i;
      a_rvalid_o <= a_gnt_o && !a_we_i;
      b_rvalid_o <= b_gnt_o && !b_we_i;
      if (a_gnt_o && !a_we_i) a_rdata_o <= mem_rdata_i;
      if (b_gnt_o && !b_we_i) b_rdata_o <= mem_rdata_i;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_b <= 1'b0;
    end else if (a_gnt_o || b_gnt_o) begin
      last_b <= a_gnt_o;
    end
  end
`else
  // Counts cycles B is kept waiting; saturates so B is forced at MAX_WAIT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (b_req_i && !b_gnt_o) begin
      if (wait_cnt != 8'(MAX_WAIT)) wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

endmodule
